// File: rtl/sram_stream_adapter.sv
// Turns a valid/ready request stream into single-port tc_sram accesses and returns read data on a valid/ready stream.
// Each read holds a credit until its response is popped, so the response FIFO can never overflow.
module sram_stream_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned FifoDepth = Latency + 2,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CreditWidth = $clog2(FifoDepth + 1);
  localparam int unsigned PtrWidth    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  logic [CreditWidth-1:0] creditCnt_q, creditCnt_d;
  logic [CreditWidth-1:0] fifoCnt_q, fifoCnt_d;
  logic [PtrWidth-1:0]    rdPtr_q, rdPtr_d;
  logic [PtrWidth-1:0]    wrPtr_q, wrPtr_d;
  logic [DataWidth-1:0]   fifoMem_q [FifoDepth];

  logic reqAccept, readAccept, fifoPush, fifoPop, fifoEmpty, fifoFull;

  function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(FifoDepth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  // Writes are gated by credits too, so they never overtake a stalled read.
  assign req_ready_o  = (creditCnt_q < CreditWidth'(FifoDepth));
  assign reqAccept    = req_valid_i && req_ready_o;
  assign readAccept   = reqAccept && !req_we_i;

  assign sram_req_o   = reqAccept;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  generate
    if (Latency == 0) begin : gen_noPipe
      assign fifoPush = readAccept;
    end else begin : gen_pipe
      logic [Latency-1:0] inflight_q, inflight_d;

      always_comb begin
        inflight_d    = inflight_q << 1;
        inflight_d[0] = readAccept;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) inflight_q <= '0;
        else         inflight_q <= inflight_d;
      end

      assign fifoPush = inflight_q[Latency-1];
    end
  endgenerate

  assign fifoEmpty   = (fifoCnt_q == '0);
  assign fifoFull    = (fifoCnt_q == CreditWidth'(FifoDepth));
  assign rsp_valid_o = !fifoEmpty;
  assign rsp_rdata_o = fifoMem_q[rdPtr_q];
  assign fifoPop     = rsp_valid_o && rsp_ready_i;

  always_comb begin
    creditCnt_d = creditCnt_q;
    if (readAccept && !fifoPop)      creditCnt_d = creditCnt_q + CreditWidth'(1);
    else if (!readAccept && fifoPop) creditCnt_d = creditCnt_q - CreditWidth'(1);
  end

  always_comb begin
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    fifoCnt_d = fifoCnt_q;
    if (fifoPush) wrPtr_d = nextPtr(wrPtr_q);
    if (fifoPop)  rdPtr_d = nextPtr(rdPtr_q);
    if (fifoPush && !fifoPop)      fifoCnt_d = fifoCnt_q + CreditWidth'(1);
    else if (!fifoPush && fifoPop) fifoCnt_d = fifoCnt_q - CreditWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      creditCnt_q <= '0;
      fifoCnt_q   <= '0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
    end else begin
      creditCnt_q <= creditCnt_d;
      fifoCnt_q   <= fifoCnt_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
    end
  end

  // Storage is cleared on reset so the idle response data reads as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FifoDepth); i++) fifoMem_q[i] <= '0;
    end else if (fifoPush) begin
      fifoMem_q[wrPtr_q] <= sram_rdata_i;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(fifoPush && fifoFull)) else $error("push into full response FIFO");
      assert (!(fifoPop && fifoEmpty)) else $error("pop from empty response FIFO");
    end
  end

  if (FifoDepth < 1) begin : gen_badDepth
    $fatal(1, "FifoDepth must be at least 1");
  end
  if (DataWidth < 1) begin : gen_badWidth
    $fatal(1, "DataWidth must be at least 1");
  end
`endif

endmodule

// File: tb/tb_sram_stream_adapter.sv
// Directed bench for sram_stream_adapter: a Latency=1 instance and a Latency=0 instance, each with a small SRAM model.
module tb_sram_stream_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  logic        reqValidA, reqReadyA, reqWeA, rspValidA, rspReadyA;
  logic [9:0]  reqAddrA, sramAddrA;
  logic [31:0] reqWdataA, rspRdataA, sramWdataA, sramRdataA;
  logic [3:0]  reqBeA, sramBeA;
  logic        sramReqA, sramWeA;

  logic        reqValidB, reqReadyB, reqWeB, rspValidB, rspReadyB;
  logic [9:0]  reqAddrB, sramAddrB;
  logic [31:0] reqWdataB, rspRdataB, sramWdataB, sramRdataB;
  logic [3:0]  reqBeB, sramBeB;
  logic        sramReqB, sramWeB;

  int checkCount = 0;
  int passCount  = 0;

  sram_stream_adapter #(.Latency(1), .FifoDepth(3)) dutA (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValidA), .req_ready_o(reqReadyA), .req_we_i(reqWeA),
    .req_addr_i(reqAddrA), .req_wdata_i(reqWdataA), .req_be_i(reqBeA),
    .rsp_valid_o(rspValidA), .rsp_ready_i(rspReadyA), .rsp_rdata_o(rspRdataA),
    .sram_req_o(sramReqA), .sram_we_o(sramWeA), .sram_addr_o(sramAddrA),
    .sram_wdata_o(sramWdataA), .sram_be_o(sramBeA), .sram_rdata_i(sramRdataA)
  );

  sram_stream_adapter #(.Latency(0)) dutB (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValidB), .req_ready_o(reqReadyB), .req_we_i(reqWeB),
    .req_addr_i(reqAddrB), .req_wdata_i(reqWdataB), .req_be_i(reqBeB),
    .rsp_valid_o(rspValidB), .rsp_ready_i(rspReadyB), .rsp_rdata_o(rspRdataB),
    .sram_req_o(sramReqB), .sram_we_o(sramWeB), .sram_addr_o(sramAddrB),
    .sram_wdata_o(sramWdataB), .sram_be_o(sramBeB), .sram_rdata_i(sramRdataB)
  );

  // One-cycle-latency SRAM behind dutA
  logic [31:0] memA [0:1023];
  always @(posedge clk) begin
    if (sramReqA) begin
      if (sramWeA) begin
        for (int b = 0; b < 4; b++)
          if (sramBeA[b]) memA[sramAddrA][b*8 +: 8] <= sramWdataA[b*8 +: 8];
      end else begin
        sramRdataA <= memA[sramAddrA];
      end
    end
  end

  // Zero-latency SRAM behind dutB
  logic [31:0] memB [0:1023];
  always @(posedge clk) begin
    if (sramReqB && sramWeB) begin
      for (int b = 0; b < 4; b++)
        if (sramBeB[b]) memB[sramAddrB][b*8 +: 8] <= sramWdataB[b*8 +: 8];
    end
  end
  assign sramRdataB = memB[sramAddrB];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input bit sel, input logic valid, input logic we, input logic [9:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    if (!sel) begin
      reqValidA = valid; reqWeA = we; reqAddrA = addr; reqWdataA = wdata; reqBeA = be;
    end else begin
      reqValidB = valid; reqWeB = we; reqAddrB = addr; reqWdataB = wdata; reqBeB = be;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    rspReadyA = 1'b1;
    rspReadyB = 1'b1;
    applyStimulus(0, 0, 0, 10'd0, 32'd0, 4'd0);
    applyStimulus(1, 0, 0, 10'd0, 32'd0, 4'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset rsp_valid A", 32'(rspValidA), 32'd0);
    checkOutput("reset rsp_rdata A", rspRdataA, 32'd0);
    checkOutput("reset req_ready A", 32'(reqReadyA), 32'd1);
    checkOutput("reset sram_req A", 32'(sramReqA), 32'd0);
    checkOutput("reset rsp_valid B", 32'(rspValidB), 32'd0);
    checkOutput("reset req_ready B", 32'(reqReadyB), 32'd1);
    rstN = 1'b1;

    // Full write then read-back: response two cycles after the read is accepted
    @(negedge clk); applyStimulus(0, 1, 1, 10'd5, 32'hDEADBEEF, 4'hF);
    #1 checkOutput("write sram_req", 32'(sramReqA), 32'd1);
    checkOutput("write sram_we", 32'(sramWeA), 32'd1);
    @(negedge clk); applyStimulus(0, 1, 0, 10'd5, 32'd0, 4'd0);
    #1 checkOutput("read sram_addr", 32'(sramAddrA), 32'd5);
    checkOutput("read sram_we", 32'(sramWeA), 32'd0);
    @(negedge clk); applyStimulus(0, 0, 0, 10'd0, 32'd0, 4'd0);
    checkOutput("rd t+1 rsp_valid", 32'(rspValidA), 32'd0);
    @(negedge clk);
    checkOutput("rd t+2 rsp_valid", 32'(rspValidA), 32'd1);
    checkOutput("rd t+2 rsp_rdata", rspRdataA, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("rd after pop rsp_valid", 32'(rspValidA), 32'd0);

    // Partial write merges enabled bytes only
    @(negedge clk); applyStimulus(0, 1, 1, 10'd2, 32'h11223344, 4'hF);
    @(negedge clk); applyStimulus(0, 1, 1, 10'd2, 32'hAABBCCDD, 4'b0101);
    @(negedge clk); applyStimulus(0, 1, 0, 10'd2, 32'd0, 4'd0);
    @(negedge clk); applyStimulus(0, 0, 0, 10'd0, 32'd0, 4'd0);
    checkOutput("partial t+1 rsp_valid", 32'(rspValidA), 32'd0);
    @(negedge clk);
    checkOutput("partial rsp_valid", 32'(rspValidA), 32'd1);
    checkOutput("partial rsp_rdata", rspRdataA, 32'h11BB33DD);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk); applyStimulus(0, 1, 1, 10'(i), 32'hA5A50000 + 32'(i), 4'hF);
    end
    @(negedge clk); applyStimulus(0, 0, 0, 10'd0, 32'd0, 4'd0);

    // Back-to-back reads at one per cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) applyStimulus(0, 1, 0, 10'(i), 32'd0, 4'd0);
      else       applyStimulus(0, 0, 0, 10'd0, 32'd0, 4'd0);
      #1;
      if (i < 8) checkOutput($sformatf("b2b req_ready %0d", i), 32'(reqReadyA), 32'd1);
      if (i < 2) checkOutput($sformatf("b2b early rsp_valid %0d", i), 32'(rspValidA), 32'd0);
      if (i >= 2) begin
        checkOutput($sformatf("b2b rsp_valid %0d", i - 2), 32'(rspValidA), 32'd1);
        checkOutput($sformatf("b2b rsp_rdata %0d", i - 2), rspRdataA, 32'hA5A50000 + 32'(i - 2));
      end
    end
    @(negedge clk);
    checkOutput("b2b drained rsp_valid", 32'(rspValidA), 32'd0);

    // Backpressure: only three reads fit while the consumer stalls
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rspReadyA = 1'b0;
      applyStimulus(0, 1, 0, 10'(c), 32'd0, 4'd0);
      #1 checkOutput($sformatf("bp req_ready %0d", c), 32'(reqReadyA), (c < 3) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        checkOutput($sformatf("bp rsp_valid %0d", c), 32'(rspValidA), 32'd1);
        checkOutput($sformatf("bp rsp_rdata stable %0d", c), rspRdataA, 32'hA5A50000);
      end
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 10'd0, 32'd0, 4'd0);
    rspReadyA = 1'b1;
    #1 checkOutput("bp release req_ready", 32'(reqReadyA), 32'd0);
    checkOutput("bp rsp 0", rspRdataA, 32'hA5A50000);
    @(negedge clk);
    checkOutput("bp req_ready after pop", 32'(reqReadyA), 32'd1);
    checkOutput("bp rsp_valid 1", 32'(rspValidA), 32'd1);
    checkOutput("bp rsp 1", rspRdataA, 32'hA5A50001);
    @(negedge clk);
    checkOutput("bp rsp_valid 2", 32'(rspValidA), 32'd1);
    checkOutput("bp rsp 2", rspRdataA, 32'hA5A50002);
    @(negedge clk);
    checkOutput("bp drained rsp_valid", 32'(rspValidA), 32'd0);
    checkOutput("bp drained req_ready", 32'(reqReadyA), 32'd1);

    // Zero-latency instance: response the cycle after accept
    @(negedge clk); applyStimulus(1, 1, 1, 10'd7, 32'h0000CAFE, 4'hF);
    @(negedge clk); applyStimulus(1, 1, 0, 10'd7, 32'd0, 4'd0);
    #1 checkOutput("lat0 sram_req", 32'(sramReqB), 32'd1);
    checkOutput("lat0 t rsp_valid", 32'(rspValidB), 32'd0);
    @(negedge clk); applyStimulus(1, 0, 0, 10'd0, 32'd0, 4'd0);
    checkOutput("lat0 t+1 rsp_valid", 32'(rspValidB), 32'd1);
    checkOutput("lat0 t+1 rsp_rdata", rspRdataB, 32'h0000CAFE);
    @(negedge clk);
    checkOutput("lat0 drained rsp_valid", 32'(rspValidB), 32'd0);

    // Reset while two reads are in flight discards them
    @(negedge clk); applyStimulus(0, 1, 0, 10'd1, 32'd0, 4'd0);
    @(negedge clk); applyStimulus(0, 1, 0, 10'd2, 32'd0, 4'd0);
    @(negedge clk); applyStimulus(0, 0, 0, 10'd0, 32'd0, 4'd0);
    rstN = 1'b0;
    #1 checkOutput("midrst rsp_valid", 32'(rspValidA), 32'd0);
    checkOutput("midrst req_ready", 32'(reqReadyA), 32'd1);
    checkOutput("midrst rsp_rdata", rspRdataA, 32'd0);
    @(negedge clk); rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst no stale rsp %0d", i), 32'(rspValidA), 32'd0);
      checkOutput($sformatf("midrst req_ready %0d", i), 32'(reqReadyA), 32'd1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sram_stream_adapter.md
Name: sram_stream_adapter

Overview:
- Converts a valid/ready request stream into single-port tc_sram accesses, and returns read data as a valid/ready response stream.
- Sits directly upstream of one tc_sram port. It drives req/we/addr/wdata/be and consumes rdata, which arrives a fixed Latency cycles later without a handshake.
- Provides credit-based flow control and a response FIFO, so read data is never lost when the consumer stalls.
- Writes produce no response.

Parameters:
- NumWords, 1024, words in attached SRAM; AddrWidth = (NumWords>1) ? $clog2(NumWords) : 1
- DataWidth, 32, data width
- ByteWidth, 8, byte width; BeWidth = ceil(DataWidth/ByteWidth)
- Latency, 1, read latency of attached SRAM; must match the SRAM instance; 0 allowed
- FifoDepth, Latency+2, response FIFO entries; >=1; Latency+2 gives full read throughput

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  AddrWidth  word address
- req_wdata_i  in  DataWidth  write data
- req_be_i  in  BeWidth  byte enables (writes only)
- rsp_valid_o  out  1  read response valid
- rsp_ready_i  in  1  read response ready
- rsp_rdata_o  out  DataWidth  read data
- sram_req_o  out  1  to SRAM req_i
- sram_we_o  out  1  to SRAM we_i
- sram_addr_o  out  AddrWidth  to SRAM addr_i
- sram_wdata_o  out  DataWidth  to SRAM wdata_i
- sram_be_o  out  BeWidth  to SRAM be_i
- sram_rdata_i  in  DataWidth  from SRAM rdata_o

Behaviour:
- Clock and reset: single clock clk_i; asynchronous active-low reset rst_ni.
- Reset state:
  - credit counter = 0; in-flight shift register cleared; FIFO empty.
  - rsp_valid_o = 0, rsp_rdata_o = 0.
  - req_ready_o = 1 (FifoDepth >= 1).
- Credit counter:
  - width $clog2(FifoDepth+1); counts reads accepted and not yet popped.
  - req_ready_o = (credits < FifoDepth), purely registered state; no combinational path from rsp_ready_i or req_valid_i.
  - Applies to reads and writes alike, so request ordering is preserved.
- Request accept: fires when req_valid_i && req_ready_o.
  - sram_req_o = req_valid_i && req_ready_o (combinational).
  - sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o are passthrough from the request.
  - Read accept increments credits; write accept leaves credits unchanged.
- Credit release: each FIFO pop (rsp_valid_o && rsp_ready_i) decrements credits at that clock edge. The freed credit is visible on req_ready_o the next cycle.
  - Read accept and pop in the same cycle: counter unchanged.
- In-flight tracking: Latency-bit shift register of read-accept flags.
  - A read accepted in cycle t has sram_rdata_i valid in cycle t+Latency.
  - Latency=0: same cycle, no shift register.
  - When the flag reaches the tail, sram_rdata_i is pushed into the FIFO at the end of that cycle.
- FIFO:
  - registered; rsp_valid_o = !empty; rsp_rdata_o = head entry.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by construction (credits cover in-flight entries plus stored entries).
  - Simulation: assert no push when full and no pop when empty.
- Latency: total read latency is Latency+1 cycles (accept at t -> rsp_valid_o at t+Latency+1). With FifoDepth >= Latency+2 and rsp_ready_i held at 1, one read is accepted per cycle.
- Stall: with rsp_ready_i=0, rsp_valid_o and rsp_rdata_o hold stable. Accepts continue until credits == FifoDepth, then req_ready_o=0.
- Writes:
  - take one SRAM cycle, no response, never enter the FIFO.
  - a read after a write to the same address returns the new data (SRAM ordering).
- Reset mid-operation: all in-flight and buffered reads are discarded; no response is issued for them.
- Parameter checks (simulation only): $fatal if FifoDepth < 1 or DataWidth < 1.

Test Plan:
- Write, then read after reset:
  - Latency=1, FifoDepth=3, rsp_ready_i=1.
  - Write addr 5 data 0xDEADBEEF, be=4'hF; then read addr 5 in cycle t.
  - Required: rsp_valid_o high in cycle t+2 with 0xDEADBEEF.
- Partial write:
  - Write 0x11223344 to addr 2, then write 0xAABBCCDD with be=4'b0101, then read addr 2.
  - Required: response 0x11BB33DD.
- Back-to-back reads at full throughput:
  - 8 consecutive reads of addrs 0..7, rsp_ready_i=1.
  - Required: req_ready_o stays 1; 8 responses on consecutive cycles, in order.
- Backpressure:
  - rsp_ready_i=0; present 5 reads with FifoDepth=3.
  - Required: exactly 3 accepted, then req_ready_o=0 and rsp_rdata_o stable.
  - Raise rsp_ready_i: 3 responses in order; req_ready_o returns to 1 the cycle after the first pop.
- Latency=0 build:
  - Read addr 7 holding 0x0000CAFE in cycle t.
  - Required: rsp_valid_o in cycle t+1 with 0x0000CAFE.
- Reset mid-flight:
  - Issue 2 reads; assert rst_ni=0 one cycle later.
  - Required: rsp_valid_o=0, req_ready_o=1 after reset, and no stale response appears.
